// File: rtl/memory_interface_unit.sv
// LC-3 memory/I-O access unit: request/ready handshake to multi-cycle
// external memory plus the KBSR/KBDR/DSR/DDR device registers.
module memory_interface_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int MEMORY_LATENCY = 2,
    parameter logic [ADDRESS_WIDTH-1:0] KBSR_ADDRESS = 16'hFE00,
    parameter logic [ADDRESS_WIDTH-1:0] KBDR_ADDRESS = 16'hFE02,
    parameter logic [ADDRESS_WIDTH-1:0] DSR_ADDRESS = 16'hFE04,
    parameter logic [ADDRESS_WIDTH-1:0] DDR_ADDRESS = 16'hFE06
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     request,
    input  logic                     write,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     ready,
    output logic                     busy,
    output logic                     memory_enable,
    output logic                     memory_write,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic [DATA_WIDTH-1:0]    memory_write_data,
    input  logic [DATA_WIDTH-1:0]    memory_read_data,
    input  logic                     keyboard_valid,
    input  logic [7:0]               keyboard_data,
    output logic                     keyboard_ready,
    output logic                     display_valid,
    output logic [7:0]               display_data,
    input  logic                     display_ready
);
    localparam int CW = (MEMORY_LATENCY > 1) ? $clog2(MEMORY_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEMORY_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, MEMORY, DEVICE, DONE} state_t;

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] mar_q;
    logic [DATA_WIDTH-1:0]    mdr_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [DATA_WIDTH-1:0]    kbdr_q;
    logic [DATA_WIDTH-1:0]    dev_rd;
    logic [CW-1:0]            lat_q;
    logic [7:0]               disp_data_q;
    logic we_q, ready_q, busy_q, mem_en_q, mem_wr_q;
    logic kbsr_q, disp_valid_q;
    logic req_dev, hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;

    assign req_dev = (address == KBSR_ADDRESS) || (address == KBDR_ADDRESS) ||
                     (address == DSR_ADDRESS) || (address == DDR_ADDRESS);
    assign hit_kbsr = (mar_q == KBSR_ADDRESS);
    assign hit_kbdr = (mar_q == KBDR_ADDRESS);
    assign hit_dsr = (mar_q == DSR_ADDRESS);
    assign hit_ddr = (mar_q == DDR_ADDRESS);

    always_comb begin
        dev_rd = '0;
        unique case (1'b1)
            hit_kbsr: dev_rd[DATA_WIDTH-1] = kbsr_q;
            hit_kbdr: dev_rd = kbdr_q;
            hit_dsr:  dev_rd[DATA_WIDTH-1] = ~disp_valid_q;
            default:  dev_rd = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mar_q <= '0;
            mdr_q <= '0;
            we_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q <= 1'b0;
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            lat_q <= '0;
            kbsr_q <= 1'b0;
            kbdr_q <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q <= '0;
        end else begin
            ready_q <= 1'b0;
            if (disp_valid_q && display_ready) begin
                disp_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (request) begin
                        mar_q <= address;
                        mdr_q <= write_data;
                        we_q <= write;
                        busy_q <= 1'b1;
                        lat_q <= '0;
                        if (req_dev) begin
                            state_q <= DEVICE;
                        end else begin
                            state_q <= MEMORY;
                            mem_en_q <= 1'b1;
                            mem_wr_q <= write;
                        end
                    end
                end
                MEMORY: begin
                    if (lat_q == LAST) begin
                        mem_en_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= memory_read_data;
                        end
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        lat_q <= lat_q + CW'(1);
                    end
                end
                DEVICE: begin
                    // A new display character waits until the previous one retires
                    if (!(hit_ddr && we_q && disp_valid_q)) begin
                        ready_q <= 1'b1;
                        state_q <= DONE;
                        if (!we_q) begin
                            rdata_q <= dev_rd;
                            if (hit_kbdr) begin
                                kbsr_q <= 1'b0;
                            end
                        end else if (hit_ddr) begin
                            disp_data_q <= mdr_q[7:0];
                            disp_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    lat_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (keyboard_valid && !kbsr_q) begin
                kbdr_q <= DATA_WIDTH'(keyboard_data);
                kbsr_q <= 1'b1;
            end
        end
    end

    assign read_data = rdata_q;
    assign ready = ready_q;
    assign busy = busy_q;
    assign memory_enable = mem_en_q;
    assign memory_write = mem_wr_q;
    assign memory_address = mar_q;
    assign memory_write_data = mdr_q;
    assign keyboard_ready = ~kbsr_q;
    assign display_valid = disp_valid_q;
    assign display_data = disp_data_q;
endmodule

// File: tb/tb_memory_interface_unit.sv
// Scoreboard bench for memory_interface_unit: directed LC-3 I/O scenarios
// followed by randomized accesses against a behavioural model.
module tb_memory_interface_unit;
    localparam int L = 3;
    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR = 16'hFE04;
    localparam logic [15:0] DDR = 16'hFE06;

    typedef struct {
        logic [15:0] data;
        int          lat;
        bit          mem;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wd;
        longint      acc;
    } item_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic request = 1'b0;
    logic write = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] write_data = '0;
    logic [15:0] read_data;
    logic ready, busy, memory_enable, memory_write;
    logic [15:0] memory_address, memory_write_data, memory_read_data;
    logic keyboard_valid = 1'b0;
    logic [7:0] keyboard_data = '0;
    logic keyboard_ready, display_valid;
    logic [7:0] display_data;
    logic display_ready = 1'b0;

    logic [15:0] extmem [0:65535];
    logic [15:0] ref_mem [0:65535];
    item_t sbq[$];
    item_t mit;
    longint cyc = 0;
    int total = 0;
    int bad = 0;
    int en_cnt = 0;
    int n_ready = 0;
    int n_issued = 0;

    bit kb_full = 0;
    logic [15:0] kbdr = '0;
    logic [15:0] last_rd = '0;
    bit pend = 0;
    logic [7:0] dchar = '0;

    memory_interface_unit #(.MEMORY_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .request(request), .write(write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .busy(busy), .memory_enable(memory_enable),
        .memory_write(memory_write), .memory_address(memory_address),
        .memory_write_data(memory_write_data),
        .memory_read_data(memory_read_data),
        .keyboard_valid(keyboard_valid), .keyboard_data(keyboard_data),
        .keyboard_ready(keyboard_ready), .display_valid(display_valid),
        .display_data(display_data), .display_ready(display_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    assign memory_read_data = extmem[memory_address];
    always @(posedge clock) begin
        if (memory_enable && memory_write) extmem[memory_address] <= memory_write_data;
    end

    always @(negedge clock) begin
        if (reset) begin
            en_cnt = 0;
        end else begin
            if (memory_enable && sbq.size() != 0) begin
                en_cnt++;
                total++;
                if (!sbq[0].mem ||
                    {memory_write, memory_address, memory_write_data} !==
                    {sbq[0].we, sbq[0].addr, sbq[0].wd}) begin
                    bad++;
                    $display("FAIL membus got we=%0b a=%h d=%h expected we=%0b a=%h d=%h",
                             memory_write, memory_address, memory_write_data,
                             sbq[0].we, sbq[0].addr, sbq[0].wd);
                end
            end
            if (ready) begin
                n_ready++;
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready got ready with read_data=%h expected no ready", read_data);
                end else begin
                    mit = sbq.pop_front();
                    if (read_data !== mit.data) begin
                        bad++;
                        $display("FAIL read_data got=%h expected=%h addr=%h", read_data, mit.data, mit.addr);
                    end
                    if (mit.lat >= 0) begin
                        total++;
                        if (int'(cyc - mit.acc) != mit.lat) begin
                            bad++;
                            $display("FAIL latency got=%0d expected=%0d addr=%h", int'(cyc - mit.acc), mit.lat, mit.addr);
                        end
                    end
                    if (mit.mem) begin
                        total++;
                        if (en_cnt != L) begin
                            bad++;
                            $display("FAIL enable_cycles got=%0d expected=%0d", en_cnt, L);
                        end
                    end
                end
                en_cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic issue(input bit w, input logic [15:0] a, input logic [15:0] d, input bit track);
        item_t it;
        bit dev;
        logic [15:0] e;
        @(negedge clock);
        request = 1'b1;
        write = w;
        address = a;
        write_data = d;
        if (track) begin
            dev = (a == KBSR) || (a == KBDR) || (a == DSR) || (a == DDR);
            e = last_rd;
            it.lat = dev ? 1 : L;
            if (!dev) begin
                if (w) ref_mem[a] = d;
                else e = ref_mem[a];
            end else if (a == KBSR) begin
                if (!w) e = {kb_full, 15'b0};
            end else if (a == KBDR) begin
                if (!w) begin
                    e = kbdr;
                    kb_full = 0;
                end
            end else if (a == DSR) begin
                if (!w) e = {~pend, 15'b0};
            end else begin
                if (w) begin
                    if (pend) it.lat = -1;
                    pend = 1;
                    dchar = d[7:0];
                end else begin
                    e = 16'h0000;
                end
            end
            last_rd = e;
            it.data = e;
            it.mem = !dev;
            it.we = w;
            it.addr = a;
            it.wd = d;
            it.acc = cyc + 1;
            sbq.push_back(it);
            n_issued++;
        end
        @(negedge clock);
        request = 1'b0;
        write = 1'($urandom);
        address = 16'($urandom);
        write_data = 16'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clock);
            #1;
            n++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL timeout got pending=%0d expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic offer(input logic [7:0] c);
        @(negedge clock);
        keyboard_valid = 1'b1;
        keyboard_data = c;
        if (!kb_full) begin
            kb_full = 1;
            kbdr = {8'h00, c};
        end
        @(negedge clock);
        keyboard_valid = 1'b0;
        keyboard_data = 8'($urandom);
    endtask

    task automatic chk_reset_outs();
        chk("rst_read_data", 32'(read_data), 0);
        chk("rst_ready_busy", 32'({ready, busy}), 0);
        chk("rst_mem_strobes", 32'({memory_enable, memory_write}), 0);
        chk("rst_mem_addr", 32'(memory_address), 0);
        chk("rst_mem_wdata", 32'(memory_write_data), 0);
        chk("rst_display", 32'({display_valid, display_data}), 0);
        chk("rst_kb_ready", 32'(keyboard_ready), 1);
    endtask

    initial begin
        logic [15:0] devs [4];
        logic [15:0] a;
        int op;
        bit w;
        devs = '{KBSR, KBDR, DSR, DDR};
        for (int i = 0; i < 65536; i++) begin
            extmem[i] = 16'(i * 7 + 3);
            ref_mem[i] = 16'(i * 7 + 3);
        end
        extmem[16'h3000] = 16'hBEEF;
        ref_mem[16'h3000] = 16'hBEEF;

        repeat (3) @(negedge clock);
        chk_reset_outs();
        reset = 1'b0;

        issue(0, 16'h3000, 16'h0000, 1);
        wait_done();
        chk("beef_read", 32'(read_data), 32'h0000BEEF);
        issue(1, 16'h0040, 16'h1234, 1);
        wait_done();
        chk("write_holds_rdata", 32'(read_data), 32'h0000BEEF);
        issue(0, 16'h0040, 16'h0000, 1);
        wait_done();

        issue(0, 16'h3001, 16'h0000, 1);
        request = 1'b1;
        write = 1'b1;
        address = 16'h3002;
        write_data = 16'hFFFF;
        @(negedge clock);
        request = 1'b0;
        wait_done();
        request = 1'b1;
        write = 1'b1;
        address = 16'h3003;
        write_data = 16'hFFFF;
        @(negedge clock);
        request = 1'b0;
        repeat (4) @(negedge clock);
        chk("ignored_req_readies", 32'(n_ready), 32'(n_issued));
        issue(0, 16'h3002, 16'h0000, 1);
        wait_done();
        issue(0, 16'h3003, 16'h0000, 1);
        wait_done();

        offer(8'h41);
        chk("kb_ready_low", 32'(keyboard_ready), 0);
        issue(0, KBSR, 16'h0000, 1);
        wait_done();
        issue(0, KBDR, 16'h0000, 1);
        keyboard_valid = 1'b1;
        keyboard_data = 8'h42;
        chk("kb_ready_in_device", 32'(keyboard_ready), 0);
        @(negedge clock);
        chk("kb_ready_in_done", 32'(keyboard_ready), 1);
        @(negedge clock);
        chk("kb_latched_late", 32'(keyboard_ready), 0);
        keyboard_valid = 1'b0;
        kb_full = 1;
        kbdr = 16'h0042;
        wait_done();
        issue(0, KBSR, 16'h0000, 1);
        wait_done();
        issue(0, KBDR, 16'h0000, 1);
        wait_done();
        issue(0, KBSR, 16'h0000, 1);
        wait_done();
        offer(8'h43);

        issue(1, DDR, 16'h0058, 1);
        wait_done();
        chk("ddr_first", 32'({display_valid, display_data}), 32'h158);
        issue(0, DSR, 16'h0000, 1);
        wait_done();
        issue(1, DDR, 16'h0059, 1);
        repeat (5) @(negedge clock);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_no_ready", 32'(sbq.size()), 1);
        chk("stall_old_char", 32'(display_data), 32'h58);
        display_ready = 1'b1;
        wait_done();
        display_ready = 1'b0;
        chk("ddr_second", 32'({display_valid, display_data}), 32'h159);

        issue(0, 16'h3004, 16'h0000, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_mem_en", 32'(memory_enable), 0);
        chk_reset_outs();
        reset = 1'b0;
        kb_full = 0;
        kbdr = '0;
        last_rd = '0;
        pend = 0;
        dchar = '0;
        repeat (6) @(negedge clock);

        display_ready = 1'b1;
        repeat (150) begin
            if ($urandom_range(3) == 0) offer(8'($urandom));
            op = $urandom_range(9);
            w = 1'($urandom);
            if (op == 0) a = 16'h0040;
            else if (op < 6) a = 16'h3000 + 16'($urandom_range(15));
            else a = devs[op-6];
            issue(w, a, 16'($urandom), 1);
            wait_done();
            if (a == DDR && w) begin
                chk("rand_display_data", 32'(display_data), 32'(dchar));
                pend = 0;
            end
            repeat ($urandom_range(2)) @(negedge clock);
        end

        repeat (4) @(negedge clock);
        chk("ready_count", 32'(n_ready), 32'(n_issued));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
